// File: rtl/lcd_refresh_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lcd_refresh_ctrl
// Purpose  : HD44780 16x2 LCD writer; initialises the panel, then streams the
//            32-byte character RAM to both display lines forever.
// Revision : 1.0 - initial release
// ============================================================================
module lcd_refresh_ctrl #(
    parameter int unsigned T_PWRUP = 750000,
    parameter int unsigned T_SETUP = 4,
    parameter int unsigned T_EN    = 16,
    parameter int unsigned T_CMD   = 2500,
    parameter int unsigned T_CLR   = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [4:0] raddr,
    input  logic [7:0] rdata,
    output logic [7:0] lcd_data,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_en,
    output logic       lcd_on,
    output logic       lcd_blon,
    output logic       init_done,
    output logic       frame_done
);

    localparam int unsigned c_max_a = (T_PWRUP > T_CLR) ? T_PWRUP : T_CLR;
    localparam int unsigned c_max_b = (T_CMD > T_EN) ? T_CMD : T_EN;
    localparam int unsigned c_max_c = (c_max_b > T_SETUP) ? c_max_b : T_SETUP;
    localparam int unsigned c_max   = (c_max_a > c_max_c) ? c_max_a : c_max_c;
    localparam int unsigned CNT_W   = $clog2(c_max + 1);

    localparam logic [CNT_W-1:0] c_pwrup_last = CNT_W'(T_PWRUP - 1);
    localparam logic [CNT_W-1:0] c_setup_last = CNT_W'(T_SETUP - 1);
    localparam logic [CNT_W-1:0] c_en_last    = CNT_W'(T_EN - 1);
    localparam logic [CNT_W-1:0] c_cmd_last   = CNT_W'(T_CMD - 1);
    localparam logic [CNT_W-1:0] c_clr_last   = CNT_W'(T_CLR - 1);
    localparam logic [2:0]       c_init_last  = 3'd4;

    typedef enum logic [1:0] {
        ST_PWRUP = 2'd0,
        ST_SETUP = 2'd1,
        ST_PULSE = 2'd2,
        ST_WAIT  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [4:0]       raddr_q, raddr_d;
    logic [7:0]       data_q, data_d;
    logic             rs_q, rs_d;
    logic             en_q, en_d;
    logic             on_q, on_d;
    logic             init_done_q, init_done_d;
    logic             frame_done_q, frame_done_d;
    logic             line_cmd_q, line_cmd_d;
    logic             w_load;
    logic [CNT_W-1:0] w_wait_last;

    function automatic logic [7:0] init_cmd(input logic [2:0] idx);
        case (idx)
            3'd0, 3'd1: init_cmd = 8'h38;
            3'd2:       init_cmd = 8'h0C;
            3'd3:       init_cmd = 8'h01;
            default:    init_cmd = 8'h06;
        endcase
    endfunction

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + 1'b1;
        idx_d        = idx_q;
        raddr_d      = raddr_q;
        data_d       = data_q;
        rs_d         = rs_q;
        on_d         = 1'b1;
        init_done_d  = init_done_q;
        frame_done_d = 1'b0;
        line_cmd_d   = line_cmd_q;
        w_load       = 1'b0;
        // Clear Display needs the long settle time; everything else is short.
        w_wait_last  = (!rs_q && data_q == 8'h01) ? c_clr_last : c_cmd_last;

        case (state_q)
            ST_PWRUP: if (cnt_q == c_pwrup_last) w_load = 1'b1;
            ST_SETUP: begin
                if (cnt_q == c_setup_last) begin
                    state_d = ST_PULSE;
                    cnt_d   = '0;
                end
            end
            ST_PULSE: begin
                if (cnt_q == c_en_last) begin
                    state_d = ST_WAIT;
                    cnt_d   = '0;
                end
            end
            default:  if (cnt_q == w_wait_last) w_load = 1'b1;
        endcase

        if (w_load) begin
            state_d = ST_SETUP;
            cnt_d   = '0;
            rs_d    = 1'b0;
            if (state_q == ST_PWRUP) begin
                idx_d  = 3'd0;
                data_d = init_cmd(3'd0);
            end else if (!init_done_q) begin
                if (idx_q == c_init_last) begin
                    init_done_d = 1'b1;
                    data_d      = {1'b1, raddr_q[4], 6'b0};
                end else begin
                    idx_d  = idx_q + 3'd1;
                    data_d = init_cmd(idx_q + 3'd1);
                end
            end else if (line_cmd_q) begin
                line_cmd_d = 1'b0;
                data_d     = {1'b1, raddr_q[4], 6'b0};
            end else begin
                rs_d   = 1'b1;
                data_d = rdata;
            end
        end

        // Advance the address one cycle early so rdata is valid at the next SETUP load.
        if (rs_q && state_d == ST_WAIT && cnt_d == w_wait_last) begin
            raddr_d      = raddr_q + 5'd1;
            frame_done_d = (raddr_q == 5'h1F);
            line_cmd_d   = (raddr_q[3:0] == 4'hF);
        end

        en_d = (state_d == ST_PULSE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_PWRUP;
            cnt_q        <= '0;
            idx_q        <= '0;
            raddr_q      <= '0;
            data_q       <= '0;
            rs_q         <= 1'b0;
            en_q         <= 1'b0;
            on_q         <= 1'b0;
            init_done_q  <= 1'b0;
            frame_done_q <= 1'b0;
            line_cmd_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            raddr_q      <= raddr_d;
            data_q       <= data_d;
            rs_q         <= rs_d;
            en_q         <= en_d;
            on_q         <= on_d;
            init_done_q  <= init_done_d;
            frame_done_q <= frame_done_d;
            line_cmd_q   <= line_cmd_d;
        end
    end

    assign raddr      = raddr_q;
    assign lcd_data   = data_q;
    assign lcd_rs     = rs_q;
    assign lcd_rw     = 1'b0;
    assign lcd_en     = en_q;
    assign lcd_on     = on_q;
    assign lcd_blon   = on_q;
    assign init_done  = init_done_q;
    assign frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_lcd_refresh_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_lcd_refresh_ctrl
// Purpose  : Directed self-checking bench for lcd_refresh_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lcd_refresh_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] raddr;
    logic [7:0] rdata;
    logic [7:0] lcd_data;
    logic       lcd_rs, lcd_rw, lcd_en, lcd_on, lcd_blon;
    logic       init_done, frame_done;

    logic [7:0] ram [32];
    assign rdata = ram[raddr];

    always #5 clk = ~clk;

    lcd_refresh_ctrl #(
        .T_PWRUP(100), .T_SETUP(2), .T_EN(4), .T_CMD(10), .T_CLR(50)
    ) dut (
        .clk(clk), .rst_n(rst_n), .raddr(raddr), .rdata(rdata),
        .lcd_data(lcd_data), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en),
        .lcd_on(lcd_on), .lcd_blon(lcd_blon), .init_done(init_done),
        .frame_done(frame_done)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // cycle index: edge 1 is the first rising edge after reset release
    int cyc;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    logic [7:0] wr_data [$];
    logic       wr_rs   [$];
    int         wr_cyc  [$];
    int         en_w    [$];
    int         fd_at   [$];
    int         stab_viol = 0, rw_viol = 0, w_viol = 0, fd_viol = 0, fd_cnt = 0;
    int         last_chg = -100, en_cnt = 0, id_cyc = -1;
    logic       en_prev = 1'b0, fd_prev = 1'b0, id_prev = 1'b0, rs_prev = 1'b0;
    logic [7:0] data_prev = 8'h00;

    always @(negedge clk) begin
        if (!rst_n) begin
            en_prev   = 1'b0;
            fd_prev   = 1'b0;
            id_prev   = 1'b0;
            last_chg  = -100;
            en_cnt    = 0;
            data_prev = lcd_data;
            rs_prev   = lcd_rs;
        end else begin
            if (lcd_rw !== 1'b0) rw_viol++;
            if (lcd_data !== data_prev || lcd_rs !== rs_prev) begin
                if (lcd_en) stab_viol++;
                last_chg = cyc;
            end
            if (lcd_en && !en_prev) begin
                if (cyc - last_chg < 2) stab_viol++;
                wr_data.push_back(lcd_data);
                wr_rs.push_back(lcd_rs);
                wr_cyc.push_back(cyc);
                en_cnt = 0;
            end
            if (lcd_en) en_cnt++;
            if (!lcd_en && en_prev) begin
                en_w.push_back(en_cnt);
                if (en_cnt != 4) w_viol++;
            end
            if (frame_done) begin
                if (fd_prev) fd_viol++;
                fd_cnt++;
                fd_at.push_back(wr_data.size());
            end
            if (init_done && !id_prev) id_cyc = cyc;
            en_prev   = lcd_en;
            fd_prev   = frame_done;
            id_prev   = init_done;
            data_prev = lcd_data;
            rs_prev   = lcd_rs;
        end
    end

    task automatic wait_writes(input int n, input int budget, input string tag);
        int k = 0;
        while (wr_data.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(tag, 32'(wr_data.size() >= n), 32'd1);
    endtask

    logic [7:0] exp_f    [34];
    logic [7:0] exp_init [5];
    int         exp_gap  [5];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 34; i++) exp_f[i] = 8'h20;
        exp_f[0]  = 8'h80;
        exp_f[1]  = 8'h48; exp_f[2]  = 8'h65; exp_f[3]  = 8'h6C; exp_f[4]  = 8'h6C; exp_f[5]  = 8'h6F;
        exp_f[17] = 8'hC0;
        exp_f[18] = 8'h57; exp_f[19] = 8'h6F; exp_f[20] = 8'h72; exp_f[21] = 8'h6C; exp_f[22] = 8'h64;
        exp_init = '{8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
        exp_gap  = '{0, 16, 16, 16, 56};

        for (int i = 0; i < 32; i++) ram[i] = 8'h20;
        ram[0]  = 8'h48; ram[1]  = 8'h65; ram[2]  = 8'h6C; ram[3]  = 8'h6C; ram[4]  = 8'h6F;
        ram[16] = 8'h57; ram[17] = 8'h6F; ram[18] = 8'h72; ram[19] = 8'h6C; ram[20] = 8'h64;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_data", 32'(lcd_data), 32'h00);
        check("rst_rs",   32'(lcd_rs),   32'd0);
        check("rst_rw",   32'(lcd_rw),   32'd0);
        check("rst_en",   32'(lcd_en),   32'd0);
        check("rst_on",   32'(lcd_on),   32'd0);
        check("rst_blon", 32'(lcd_blon), 32'd0);
        check("rst_raddr", 32'(raddr),   32'd0);
        check("rst_init_done",  32'(init_done),  32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);

        rst_n = 1'b1;
        @(negedge clk);
        check("on_after_rst",   32'(lcd_on),   32'd1);
        check("blon_after_rst", 32'(lcd_blon), 32'd1);

        // Init sequence
        wait_writes(6, 400, "init_writes");
        check("first_rise_cyc", 32'(wr_cyc[0]), 32'd102);
        check("first_en_width", 32'(en_w[0]), 32'd4);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("init_w%0d", i), {23'd0, wr_rs[i], wr_data[i]}, {24'd0, exp_init[i]});
            if (i > 0) check($sformatf("init_gap%0d", i), 32'(wr_cyc[i] - wr_cyc[i-1]), 32'(exp_gap[i]));
        end
        check("init_done_cyc", 32'(id_cyc), 32'd220);
        check("gap_to_0x80", 32'(wr_cyc[5] - wr_cyc[4]), 32'd16);

        // Frame 1 and start of frame 2
        wait_writes(41, 1200, "frame1_writes");
        for (int i = 0; i < 34; i++) begin
            check($sformatf("f1_w%0d", i), {23'd0, wr_rs[5+i], wr_data[5+i]},
                  {23'd0, (i != 0 && i != 17), exp_f[i]});
        end
        check("f2_first_cmd", 32'(wr_data[39]), 32'h80);
        check("fd_count", 32'(fd_cnt), 32'd1);
        check("fd_position", 32'(fd_at[0]), 32'd39);
        ram[16] = 8'h58;

        wait_writes(58, 600, "frame2_writes");
        check("f2_line2_cmd",  32'(wr_data[56]), 32'hC0);
        check("f2_line2_char", {23'd0, wr_rs[57], wr_data[57]}, {23'd1, 8'h58});
        check("f2_char_gap", 32'(wr_cyc[57] - wr_cyc[56]), 32'd16);
        check("fd_width", 32'(fd_viol), 32'd0);
        check("bus_stable", 32'(stab_viol), 32'd0);
        check("rw_low", 32'(rw_viol), 32'd0);
        check("en_widths", 32'(w_viol), 32'd0);

        // Reset asserted mid character write
        begin
            int k = 0;
            while (!(lcd_en && lcd_rs) && k < 100) begin
                @(negedge clk);
                k++;
            end
            check("found_char_pulse", 32'(lcd_en && lcd_rs), 32'd1);
        end
        #2 rst_n = 1'b0;
        #1;
        check("midrst_en",    32'(lcd_en),    32'd0);
        check("midrst_data",  32'(lcd_data),  32'h00);
        check("midrst_raddr", 32'(raddr),     32'd0);
        check("midrst_init",  32'(init_done), 32'd0);
        wr_data.delete(); wr_rs.delete(); wr_cyc.delete(); en_w.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_writes(1, 400, "restart_write");
        check("restart_cyc",  32'(wr_cyc[0]),  32'd102);
        check("restart_data", {23'd0, wr_rs[0], wr_data[0]}, {24'd0, 8'h38});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
